// File: rtl/nibbler_core.sv
// rtl/nibbler_core.sv - two-phase fetch/execute accumulator CPU with carry/zero flags
// Program ROM is external; data RAM and handshaked I/O channels are internal.
module nibbler_core #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 12,
  parameter int DMEM_AW = 8,
  parameter int N_IN    = 3,
  parameter int N_OUT   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_W-1:0]       pc,
  input  logic [3+ADDR_W:0]       instr,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_strobe,
  output logic [DATA_W-1:0]       acc,
  output logic                    c_flag,
  output logic                    z_flag,
  output logic                    fetch_phase
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3,
                         OP_ADDI = 4'h4, OP_ADD = 4'h5, OP_SUBI = 4'h6, OP_CMPI = 4'h7,
                         OP_NANDI = 4'h8, OP_JMP = 4'h9, OP_JC = 4'hA, OP_JNC = 4'hB,
                         OP_JZ = 4'hC, OP_JNZ = 4'hD, OP_IN = 4'hE, OP_OUT = 4'hF;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         pc_q, pc_d;
  logic [DATA_W-1:0]         a_q, a_d;
  logic                      c_q, c_d, z_q, z_d;
  logic [3+ADDR_W:0]         ir_q, ir_d;
  logic [N_OUT*DATA_W-1:0]   out_data_q, out_data_d;
  logic [N_OUT-1:0]          out_strobe_q, out_strobe_d;
  logic [DATA_W-1:0]         mem_q [2**DMEM_AW];
  logic                      mem_we;

  logic [3:0]                op;
  logic [ADDR_W-1:0]         operand;
  logic [DATA_W-1:0]         imm, mem_rd, alu_b;
  logic [DMEM_AW-1:0]        maddr;
  logic [DATA_W:0]           sum;
  logic [DATA_W-1:0]         diff;
  logic                      no_borrow;

  logic                      in_hit, in_sel_valid;
  logic [DATA_W-1:0]         in_sel_data;
  logic [N_IN-1:0]           in_onehot;
  logic                      out_hit;
  logic [N_OUT-1:0]          out_onehot;

  assign op        = ir_q[ADDR_W +: 4];
  assign operand   = ir_q[ADDR_W-1:0];
  assign imm       = operand[DATA_W-1:0];
  assign maddr     = operand[DMEM_AW-1:0];
  assign mem_rd    = mem_q[maddr];
  assign alu_b     = (op == OP_ADD) ? mem_rd : imm;
  assign sum       = {1'b0, a_q} + {1'b0, alu_b};
  assign diff      = a_q - imm;
  assign no_borrow = (a_q >= imm);

  // Channel decode compares the full operand so out-of-range channels never alias.
  always_comb begin
    in_hit       = 1'b0;
    in_sel_valid = 1'b0;
    in_sel_data  = '0;
    in_onehot    = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (operand == ADDR_W'(k)) begin
        in_hit       = 1'b1;
        in_sel_valid = in_valid[k];
        in_sel_data  = in_data[k*DATA_W +: DATA_W];
        in_onehot[k] = 1'b1;
      end
    end
    out_hit    = 1'b0;
    out_onehot = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (operand == ADDR_W'(k)) begin
        out_hit       = 1'b1;
        out_onehot[k] = 1'b1;
      end
    end
  end

  assign in_ready = (state_q == S_EXEC && op == OP_IN) ? (in_onehot & in_valid) : '0;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    a_d          = a_q;
    c_d          = c_q;
    z_d          = z_q;
    ir_d         = ir_q;
    out_data_d   = out_data_q;
    out_strobe_d = '0;
    mem_we       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_EXEC;
      end
      default: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 1'b1;
        case (op)
          OP_LDI: a_d = imm;
          OP_LD:  a_d = mem_rd;
          OP_ST:  mem_we = 1'b1;
          OP_ADDI, OP_ADD: begin
            a_d = sum[DATA_W-1:0];
            c_d = sum[DATA_W];
            z_d = (sum[DATA_W-1:0] == '0);
          end
          OP_SUBI, OP_CMPI: begin
            if (op == OP_SUBI) a_d = diff;
            c_d = no_borrow;
            z_d = (diff == '0);
          end
          OP_NANDI: begin
            a_d = ~(a_q & imm);
            z_d = ((a_q & imm) == '1);
          end
          OP_JMP: pc_d = operand;
          OP_JC:  if (c_q)  pc_d = operand;
          OP_JNC: if (!c_q) pc_d = operand;
          OP_JZ:  if (z_q)  pc_d = operand;
          OP_JNZ: if (!z_q) pc_d = operand;
          OP_IN: begin
            if (in_hit && !in_sel_valid) begin
              state_d = S_EXEC;
              pc_d    = pc_q;
            end else begin
              a_d = in_hit ? in_sel_data : '0;
            end
          end
          OP_OUT: begin
            if (out_hit) begin
              for (int k = 0; k < N_OUT; k++) begin
                if (out_onehot[k]) out_data_d[k*DATA_W +: DATA_W] = a_q;
              end
              out_strobe_d = out_onehot;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      a_q          <= '0;
      c_q          <= 1'b0;
      z_q          <= 1'b0;
      ir_q         <= '0;
      out_data_q   <= '0;
      out_strobe_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      a_q          <= a_d;
      c_q          <= c_d;
      z_q          <= z_d;
      ir_q         <= ir_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[maddr] <= a_q;
  end

  assign pc          = pc_q;
  assign acc         = a_q;
  assign c_flag      = c_q;
  assign z_flag      = z_q;
  assign out_data    = out_data_q;
  assign out_strobe  = out_strobe_q;
  assign fetch_phase = (state_q == S_FETCH);

endmodule

// File: tb/tb_nibbler_core.sv
// tb/tb_nibbler_core.sv - directed scoreboard bench for nibbler_core
// Two instances: default 4-bit build and an 8-bit, 5-channel build.
module tb_nibbler_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic        reset1;
  logic [11:0] pc1;
  logic [15:0] instr1;
  logic [11:0] in_data1;
  logic [2:0]  in_valid1, in_ready1, out_strobe1;
  logic [11:0] out_data1;
  logic [3:0]  acc1;
  logic        c1, z1, fp1;
  logic [15:0] rom1 [4096];
  assign instr1 = rom1[pc1];

  nibbler_core u_dut1 (
    .clk(clk), .reset(reset1), .pc(pc1), .instr(instr1),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_strobe(out_strobe1), .acc(acc1),
    .c_flag(c1), .z_flag(z1), .fetch_phase(fp1)
  );

  // Wide build
  logic        reset2;
  logic [11:0] pc2;
  logic [15:0] instr2;
  logic [39:0] in_data2;
  logic [4:0]  in_valid2, in_ready2, out_strobe2;
  logic [39:0] out_data2;
  logic [7:0]  acc2;
  logic        c2, z2, fp2;
  logic [15:0] rom2 [4096];
  assign instr2 = rom2[pc2];

  nibbler_core #(.DATA_W(8), .ADDR_W(12), .DMEM_AW(8), .N_IN(5), .N_OUT(5)) u_dut2 (
    .clk(clk), .reset(reset2), .pc(pc2), .instr(instr2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_strobe(out_strobe2), .acc(acc2),
    .c_flag(c2), .z_flag(z2), .fetch_phase(fp2)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start1();
    reset1 = 1'b1;
    #1;
    for (int i = 0; i < 4096; i++) rom1[i] = 16'h0000;
  endtask

  task automatic release1();
    @(negedge clk);
    reset1 = 1'b0;
  endtask

  initial begin
    reset1 = 1'b1; reset2 = 1'b1;
    in_data1 = '0; in_valid1 = '0;
    in_data2 = '0; in_valid2 = '0;
    for (int i = 0; i < 4096; i++) rom2[i] = 16'h0000;

    // Reset state and LDI 9; ADDI 8
    start1();
    rom1[0] = 16'h1009; rom1[1] = 16'h4008;
    push("rst_pc", 0); push("rst_acc", 0); push("rst_fetch", 1); push("rst_out", 0);
    check(pc1); check(acc1); check(fp1); check(out_data1);
    release1();
    push("addi_acc", 4'h1); push("addi_c", 1); push("addi_z", 0); push("addi_pc", 2);
    step(4);
    check(acc1); check(c1); check(z1); check(pc1);

    // LDI 5; CMPI 5; JZ 0x020
    start1();
    rom1[0] = 16'h1005; rom1[1] = 16'h7005; rom1[2] = 16'hC020;
    release1();
    push("cmpeq_acc", 5); push("cmpeq_z", 1); push("cmpeq_c", 1); push("jz_taken_pc", 12'h020);
    step(6);
    check(acc1); check(z1); check(c1); check(pc1);

    // LDI 5; CMPI 6; JZ 0x020 falls through
    start1();
    rom1[0] = 16'h1005; rom1[1] = 16'h7006; rom1[2] = 16'hC020;
    release1();
    push("cmplt_c", 0); push("cmplt_z", 0); push("jz_fall_pc", 3);
    step(6);
    check(c1); check(z1); check(pc1);

    // ST/LD round trip then ADD from RAM
    start1();
    rom1[0] = 16'h1007; rom1[1] = 16'h3003; rom1[2] = 16'h1000; rom1[3] = 16'h2003;
    rom1[4] = 16'h100F; rom1[5] = 16'h5003;
    release1();
    push("ld_acc", 7);
    step(8);
    check(acc1);
    push("add_acc", 6); push("add_c", 1);
    step(4);
    check(acc1); check(c1);

    // IN 1 stall, release, then IN 7 out-of-range
    start1();
    rom1[0] = 16'hE001; rom1[1] = 16'hE007;
    release1();
    push("stall_pc", 0); push("stall_acc", 0); push("stall_ready", 0); push("stall_exec", 0);
    step(6);
    check(pc1); check(acc1); check(in_ready1); check(fp1);
    in_data1 = 12'h0A0; in_valid1 = 3'b010;
    #1;
    push("in_ready_pulse", 3'b010);
    check(in_ready1);
    step(1);
    in_valid1 = 3'b000;
    push("in_acc", 4'hA); push("in_pc", 1); push("in_ready_drop", 0);
    check(acc1); check(pc1); check(in_ready1);
    push("in7_acc", 0); push("in7_pc", 2);
    step(2);
    check(acc1); check(pc1);

    // OUT 2, OUT 5, reset during IN stall
    start1();
    rom1[0] = 16'h1006; rom1[1] = 16'hF002; rom1[2] = 16'hF005; rom1[3] = 16'hE000;
    release1();
    push("out2_data", 12'h600); push("out2_strobe", 3'b100);
    step(4);
    check(out_data1); check(out_strobe1);
    push("out2_strobe_drop", 0);
    step(1);
    check(out_strobe1);
    push("out5_data", 12'h600); push("out5_strobe", 0);
    step(1);
    check(out_data1); check(out_strobe1);
    push("stall0_pc", 3);
    step(2);
    check(pc1);
    in_valid1 = 3'b001;
    #1;
    push("stall0_ready", 3'b001);
    check(in_ready1);
    reset1 = 1'b1;
    #1;
    push("mid_rst_pc", 0); push("mid_rst_acc", 0); push("mid_rst_out", 0);
    push("mid_rst_ready", 0); push("mid_rst_fetch", 1);
    check(pc1); check(acc1); check(out_data1); check(in_ready1); check(fp1);
    in_valid1 = 3'b000;

    // JMP 0xFFF wraps to 0
    start1();
    rom1[0] = 16'h9FFF;
    release1();
    push("jmp_pc", 12'hFFF);
    step(2);
    check(pc1);
    push("wrap_pc", 0);
    step(2);
    check(pc1);

    // Wide build: arithmetic and channel 4 I/O
    rom2[0] = 16'h10F0; rom2[1] = 16'h4020; rom2[2] = 16'hE004; rom2[3] = 16'hF004;
    @(negedge clk);
    reset2 = 1'b0;
    push("w_acc", 8'h10); push("w_c", 1); push("w_z", 0);
    step(4);
    check(acc2); check(c2); check(z2);
    push("w_stall_pc", 2);
    step(3);
    check(pc2);
    in_data2 = 40'h5A_0000_0000; in_valid2 = 5'b10000;
    #1;
    push("w_in_ready", 5'b10000);
    check(in_ready2);
    step(1);
    in_valid2 = '0;
    push("w_in_acc", 8'h5A); push("w_in_pc", 3);
    check(acc2); check(pc2);
    push("w_out_strobe", 5'b10000); push("w_out_data", 40'h5A_0000_0000);
    step(2);
    check(out_strobe2); check(out_data2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibbler_core.md
Name: nibbler_core

Overview:
- Parametrised successor of the 4-bit Nibbler processor board.
- Two-phase fetch/execute CPU with accumulator A and carry/zero flags, generalised in data width, program-address width, data-memory depth and I/O channel count.
- Fetches from an external program ROM, holds data RAM internally, and adds valid/ready handshaking on inputs plus one-cycle strobes on outputs. The original board has no I/O handshake.

Parameters:
DATA_W, 4, accumulator/data/ALU width
ADDR_W, 12, program-address and operand-field width; DATA_W <= ADDR_W
DMEM_AW, 8, data-RAM address bits (depth 2**DMEM_AW); DMEM_AW <= ADDR_W
N_IN, 3, input channels, >= 1
N_OUT, 3, output channels, >= 1

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high
pc  out  ADDR_W  program-ROM address
instr  in  4+ADDR_W  program word {opcode[3:0], operand[ADDR_W-1:0]}, combinational from ROM
in_data  in  N_IN*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
in_valid  in  N_IN  channel k has data
in_ready  out  N_IN  one-cycle consume pulse
out_data  out  N_OUT*DATA_W  registered output ports
out_strobe  out  N_OUT  one-cycle write pulse
acc  out  DATA_W  accumulator A
c_flag  out  1  carry flag
z_flag  out  1  zero flag
fetch_phase  out  1  high in FETCH state

Behaviour:
- Reset (async): state=FETCH, pc=0, A=0, C=0, Z=0, instruction register=0, out_data=0, out_strobe=0, in_ready=0. Data RAM is not reset.
- FSM states:
  - FETCH: the instruction register captures instr; go to EXEC.
  - EXEC: execute; pc <= target or pc+1; go to FETCH.
  - Exception: IN on a valid channel with in_valid low stays in EXEC, with pc, A and flags frozen.
- Each instruction takes 2 cycles, or 2+stall cycles for IN.
- pc increments mod 2**ADDR_W; 2**ADDR_W-1 wraps to 0.
- Operand fields: imm = operand[DATA_W-1:0]; mem = operand[DMEM_AW-1:0]; ch = full operand as unsigned.
- Opcodes:
  - 0 NOP.
  - 1 LDI: A<=imm.
  - 2 LD: A<=RAM[mem].
  - 3 ST: RAM[mem]<=A.
  - 4 ADDI / 5 ADD (B=RAM[mem]): {C,A}<=A+B; Z<=(result==0).
  - 6 SUBI: A<=A-imm; C<=(A>=imm), meaning no borrow; Z<=(result==0).
  - 7 CMPI: flags as SUBI; A unchanged.
  - 8 NANDI: A<=~(A&imm); Z updated; C unchanged.
  - 9 JMP: pc<=operand.
  - A JC / B JNC / C JZ / D JNZ: pc<=operand if the condition holds, else pc+1.
  - E IN: if ch<N_IN, wait until in_valid[ch]; on that EXEC cycle A<=in_data[ch] and in_ready[ch]=1 for exactly that cycle. If ch>=N_IN, A<=0 with no stall.
  - F OUT: if ch<N_OUT, out_data[ch]<=A and out_strobe[ch]=1 for the following cycle only. If ch>=N_OUT, no effect.
- Flags:
  - Only opcodes 4-8 modify flags.
  - LD, LDI and IN leave flags unchanged.
- Widths: arithmetic wraps mod 2**DATA_W; the carry is bit DATA_W of the (DATA_W+1)-bit sum.
- Strobes:
  - in_ready is combinational: EXEC & opcode==E & in_valid[ch].
  - At most one in_ready bit and one out_strobe bit is high at any time.
- RAM: synchronous write at the end of the ST EXEC cycle; asynchronous read, so an LD directly after an ST to the same address returns the new value.
- Reset mid-operation (including mid-stall) immediately returns all listed outputs to reset values; any pending strobe is cancelled.

Test Plan:
- Reset, program LDI 9; ADDI 8 -> after 4 cycles A=1, C=1, Z=0; pc=2.
- LDI 5; CMPI 5; JZ 0x020 -> A=5, Z=1, C=1; next fetch pc=0x020. Repeat with CMPI 6 -> C=0, Z=0, pc falls through to 3.
- LDI 7; ST 0x03; LDI 0; LD 0x03 -> A=7. Then LDI 0xF; ADD 0x03 -> A=6, C=1.
- IN 1 with in_valid[1]=0 for 5 cycles -> pc and A frozen, in_ready=0. Raise in_valid[1] with in_data ch1=0xA -> in_ready[1] high 1 cycle, A=0xA, pc advances. IN 7 -> A=0, no stall.
- LDI 6; OUT 2 -> out_data ch2=6, out_strobe=3'b100 for one cycle. OUT 5 -> no port or strobe change. Reset asserted mid IN-stall -> pc=0, A=0, out_data=0, in_ready=0 without a clock edge.
- JMP 0xFFF; ROM word 0xFFF=NOP -> next fetch pc=0x000 (wrap). Rerun tests 1 and 4 with DATA_W=8, N_IN=N_OUT=5: LDI 0xF0; ADDI 0x20 -> A=0x10, C=1.
